// File: rtl/ga_regfile_pkg.sv
// Shared constants and types for the GA configuration/status register file.
package ga_regfile_pkg;

  localparam int unsigned GA_M_MAX_W = 8;
  localparam int unsigned GA_P_MAX_W = 8;
  localparam int unsigned GA_B_MAX_W = 8;
  localparam int unsigned GA_G_MAX_W = 8;
  localparam int unsigned GA_ADDR_W  = 3;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 4;

  // register map
  localparam int unsigned A_CTRL   = 0;
  localparam int unsigned A_M_SH   = 1;
  localparam int unsigned A_P_SH   = 2;
  localparam int unsigned A_B_SH   = 3;
  localparam int unsigned A_G_SH   = 4;
  localparam int unsigned A_STATUS = 5;
  localparam int unsigned A_INPUTS = 6;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_COMMIT_BIT = 1;

  localparam int unsigned ST_READY_BIT = 0;
  localparam int unsigned ST_PEND_BIT  = 1;
  localparam int unsigned ST_ERR_BIT   = 2;

  typedef enum logic {BOOT, RUN} fsm_e;

endpackage

// File: rtl/ga_regfile_if.sv
// Request/acknowledge register bus between software and the GA register file.
interface ga_regfile_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              reg_wr_req;
  logic              reg_rd_req;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic              reg_ack;
  logic [31:0]       reg_rdata;
  logic              reg_err;

  modport master (
    output reg_wr_req, reg_rd_req, reg_addr, reg_wdata,
    input  reg_ack, reg_rdata, reg_err
  );

  modport slave (
    input  reg_wr_req, reg_rd_req, reg_addr, reg_wdata,
    output reg_ack, reg_rdata, reg_err
  );
endinterface

// File: rtl/ga_regfile_bus_if.sv
// Register bus front end: decode, error checking, sticky error and the
// registered ack/rdata/err stage. Write strobes to the top are combinational.
module ga_regfile_bus_if
  import ga_regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = GA_ADDR_W,
  parameter int unsigned M_W    = GA_M_MAX_W,
  parameter int unsigned P_W    = GA_P_MAX_W,
  parameter int unsigned B_W    = GA_B_MAX_W,
  parameter int unsigned G_W    = GA_G_MAX_W
) (
  input  logic              clk,
  input  logic              rstn,
  ga_regfile_if.slave       bus,
  input  logic              i_run,
  input  logic              i_ctrl_en,
  input  logic              i_commit_pending,
  input  logic              i_ga_ready,
  input  logic [M_W-1:0]    i_m_sh,
  input  logic [P_W-1:0]    i_p_sh,
  input  logic [B_W-1:0]    i_b_sh,
  input  logic [G_W-1:0]    i_g_sh,
  input  logic [DATA_W-1:0] i_inputs_counter,
  output logic              o_ctrl_we_c,
  output logic              o_ctrl_en_c,
  output logic              o_commit_c,
  output logic              o_m_we_c,
  output logic              o_p_we_c,
  output logic              o_b_we_c,
  output logic              o_g_we_c,
  output logic [M_W-1:0]    o_m_wd_c,
  output logic [P_W-1:0]    o_p_wd_c,
  output logic [B_W-1:0]    o_b_wd_c,
  output logic [G_W-1:0]    o_g_wd_c
);

  logic              w_addr_ok;
  logic              w_ro;
  logic              w_shadow;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_req;
  logic              w_err;
  logic              w_wr_ok;
  logic              w_is_status;
  logic              r_sticky;
  logic              r_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  // address decode and read-value mux
  always_comb begin
    w_addr_ok   = 1'b1;
    w_ro        = 1'b0;
    w_shadow    = 1'b0;
    w_is_status = 1'b0;
    w_rd_val    = '0;
    case (bus.reg_addr)
      ADDR_W'(A_CTRL):   w_rd_val[CTRL_EN_BIT] = i_ctrl_en;
      ADDR_W'(A_M_SH):   begin w_shadow = 1'b1; w_rd_val = DATA_W'(i_m_sh); end
      ADDR_W'(A_P_SH):   begin w_shadow = 1'b1; w_rd_val = DATA_W'(i_p_sh); end
      ADDR_W'(A_B_SH):   begin w_shadow = 1'b1; w_rd_val = DATA_W'(i_b_sh); end
      ADDR_W'(A_G_SH):   begin w_shadow = 1'b1; w_rd_val = DATA_W'(i_g_sh); end
      ADDR_W'(A_STATUS): begin
        w_is_status            = 1'b1;
        w_rd_val[ST_READY_BIT] = i_ga_ready;
        w_rd_val[ST_PEND_BIT]  = i_commit_pending;
        w_rd_val[ST_ERR_BIT]   = r_sticky;
      end
      ADDR_W'(A_INPUTS): begin w_ro = 1'b1; w_rd_val = i_inputs_counter; end
      default:           w_addr_ok = 1'b0;
    endcase
  end

  assign w_req = bus.reg_wr_req | bus.reg_rd_req;

  // anything in BOOT is rejected; in RUN only malformed accesses are
  assign w_err = w_req & (~i_run
                        | (bus.reg_wr_req & bus.reg_rd_req)
                        | ~w_addr_ok
                        | (bus.reg_wr_req & w_ro)
                        | (bus.reg_wr_req & w_shadow & (bus.reg_wdata == '0)));

  assign w_wr_ok = bus.reg_wr_req & ~w_err;

  assign o_ctrl_we_c = w_wr_ok & (bus.reg_addr == ADDR_W'(A_CTRL));
  assign o_m_we_c    = w_wr_ok & (bus.reg_addr == ADDR_W'(A_M_SH));
  assign o_p_we_c    = w_wr_ok & (bus.reg_addr == ADDR_W'(A_P_SH));
  assign o_b_we_c    = w_wr_ok & (bus.reg_addr == ADDR_W'(A_B_SH));
  assign o_g_we_c    = w_wr_ok & (bus.reg_addr == ADDR_W'(A_G_SH));
  assign o_ctrl_en_c = bus.reg_wdata[CTRL_EN_BIT];
  assign o_commit_c  = bus.reg_wdata[CTRL_COMMIT_BIT];
  assign o_m_wd_c    = M_W'(bus.reg_wdata);
  assign o_p_wd_c    = P_W'(bus.reg_wdata);
  assign o_b_wd_c    = B_W'(bus.reg_wdata);
  assign o_g_wd_c    = G_W'(bus.reg_wdata);

  // response stage and sticky error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_err   <= w_err;
      r_rdata <= (bus.reg_rd_req & ~w_err) ? w_rd_val : '0;
      if (w_err & i_run)
        r_sticky <= 1'b1;
      else if (w_wr_ok & w_is_status)
        r_sticky <= 1'b0;
    end
  end

  assign bus.reg_ack   = r_ack;
  assign bus.reg_err   = r_err;
  assign bus.reg_rdata = r_rdata;

endmodule

// File: rtl/ga_regfile.sv
// GA configuration register file: timed boot, shadow configuration and
// atomic commit of shadow into the active configuration while ga_ready.
module ga_regfile
  import ga_regfile_pkg::*;
#(
  parameter int unsigned M_MAX_W   = GA_M_MAX_W,
  parameter int unsigned P_MAX_W   = GA_P_MAX_W,
  parameter int unsigned B_MAX_W   = GA_B_MAX_W,
  parameter int unsigned G_MAX_W   = GA_G_MAX_W,
  parameter int unsigned ADDR_W    = GA_ADDR_W,
  parameter int unsigned START_DLY = 9,
  parameter int unsigned DEF_M     = 7,
  parameter int unsigned DEF_P     = 16,
  parameter int unsigned DEF_B     = 16,
  parameter int unsigned DEF_G     = 10
) (
  input  logic               clk,
  input  logic               rstn,
  ga_regfile_if.slave        bus,
  input  logic               ga_ready,
  input  logic [DATA_W-1:0]  inputs_counter,
  output logic               ga_enable,
  output logic [M_MAX_W-1:0] cnfg_m,
  output logic [P_MAX_W-1:0] cnfg_p,
  output logic [B_MAX_W-1:0] cnfg_b,
  output logic [G_MAX_W-1:0] cnfg_g
);

  fsm_e               r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ctrl_en;
  logic               r_pending;
  logic [M_MAX_W-1:0] r_m_sh, r_m_act;
  logic [P_MAX_W-1:0] r_p_sh, r_p_act;
  logic [B_MAX_W-1:0] r_b_sh, r_b_act;
  logic [G_MAX_W-1:0] r_g_sh, r_g_act;

  logic               w_ctrl_we, w_ctrl_en, w_commit;
  logic               w_m_we, w_p_we, w_b_we, w_g_we;
  logic [M_MAX_W-1:0] w_m_wd;
  logic [P_MAX_W-1:0] w_p_wd;
  logic [B_MAX_W-1:0] w_b_wd;
  logic [G_MAX_W-1:0] w_g_wd;

  ga_regfile_bus_if #(
    .ADDR_W (ADDR_W),
    .M_W    (M_MAX_W),
    .P_W    (P_MAX_W),
    .B_W    (B_MAX_W),
    .G_W    (G_MAX_W)
  ) u_bus (
    .clk              (clk),
    .rstn             (rstn),
    .bus              (bus),
    .i_run            (r_state == RUN),
    .i_ctrl_en        (r_ctrl_en),
    .i_commit_pending (r_pending),
    .i_ga_ready       (ga_ready),
    .i_m_sh           (r_m_sh),
    .i_p_sh           (r_p_sh),
    .i_b_sh           (r_b_sh),
    .i_g_sh           (r_g_sh),
    .i_inputs_counter (inputs_counter),
    .o_ctrl_we_c      (w_ctrl_we),
    .o_ctrl_en_c      (w_ctrl_en),
    .o_commit_c       (w_commit),
    .o_m_we_c         (w_m_we),
    .o_p_we_c         (w_p_we),
    .o_b_we_c         (w_b_we),
    .o_g_we_c         (w_g_we),
    .o_m_wd_c         (w_m_wd),
    .o_p_wd_c         (w_p_wd),
    .o_b_wd_c         (w_b_wd),
    .o_g_wd_c         (w_g_wd)
  );

  // boot FSM, shadow/active registers and commit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= BOOT;
      r_cnt     <= '0;
      r_ctrl_en <= 1'b0;
      r_pending <= 1'b0;
      r_m_sh    <= '0;
      r_p_sh    <= '0;
      r_b_sh    <= '0;
      r_g_sh    <= '0;
      r_m_act   <= '0;
      r_p_act   <= '0;
      r_b_act   <= '0;
      r_g_act   <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          if (r_cnt == CNT_W'(START_DLY)) begin
            r_m_sh    <= M_MAX_W'(DEF_M);
            r_p_sh    <= P_MAX_W'(DEF_P);
            r_b_sh    <= B_MAX_W'(DEF_B);
            r_g_sh    <= G_MAX_W'(DEF_G);
            r_m_act   <= M_MAX_W'(DEF_M);
            r_p_act   <= P_MAX_W'(DEF_P);
            r_b_act   <= B_MAX_W'(DEF_B);
            r_g_act   <= G_MAX_W'(DEF_G);
            r_ctrl_en <= 1'b1;
            r_state   <= RUN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (w_ctrl_we) r_ctrl_en <= w_ctrl_en;
          if (w_m_we)    r_m_sh    <= w_m_wd;
          if (w_p_we)    r_p_sh    <= w_p_wd;
          if (w_b_we)    r_b_sh    <= w_b_wd;
          if (w_g_we)    r_g_sh    <= w_g_wd;
          // active takes the pre-write shadow when a shadow write lands on the commit cycle
          if (r_pending && ga_ready) begin
            r_m_act   <= r_m_sh;
            r_p_act   <= r_p_sh;
            r_b_act   <= r_b_sh;
            r_g_act   <= r_g_sh;
            r_pending <= 1'b0;
          end else if (w_ctrl_we && w_commit) begin
            r_pending <= 1'b1;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign ga_enable = r_ctrl_en;
  assign cnfg_m    = r_m_act;
  assign cnfg_p    = r_p_act;
  assign cnfg_b    = r_b_act;
  assign cnfg_g    = r_g_act;

endmodule

// File: tb/tb_ga_regfile.sv
// Scoreboard bench for ga_regfile: bus responses are queued when requests are
// driven and compared on ack; configuration outputs are checked directly.
module tb_ga_regfile;
  import ga_regfile_pkg::*;

  localparam int unsigned MW  = 8;
  localparam int unsigned PW  = 8;
  localparam int unsigned BW  = 8;
  localparam int unsigned GW  = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned DLY = 9;
  localparam int unsigned G_TRUNC = 1000 % (1 << GW);
  localparam logic [31:0] CNT_VAL = 32'hCAFE_0123;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ga_ready;
  logic [31:0]   inputs_counter;
  logic          ga_enable;
  logic [MW-1:0] cnfg_m;
  logic [PW-1:0] cnfg_p;
  logic [BW-1:0] cnfg_b;
  logic [GW-1:0] cnfg_g;

  ga_regfile_if #(.ADDR_W(AW)) bus ();

  ga_regfile #(
    .M_MAX_W(MW), .P_MAX_W(PW), .B_MAX_W(BW), .G_MAX_W(GW), .ADDR_W(AW),
    .START_DLY(DLY), .DEF_M(7), .DEF_P(16), .DEF_B(16), .DEF_G(10)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .bus            (bus),
    .ga_ready       (ga_ready),
    .inputs_counter (inputs_counter),
    .ga_enable      (ga_enable),
    .cnfg_m         (cnfg_m),
    .cnfg_p         (cnfg_p),
    .cnfg_b         (cnfg_b),
    .cnfg_g         (cnfg_g)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // response monitor: pop expectation on each ack
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.reg_ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_latency", cyc, e.cyc + 1);
        check("rdata", bus.reg_rdata, e.data);
        check("err", 32'(bus.reg_err), 32'(e.err));
      end
    end
  end

  task automatic bus_op(input logic wr, input logic rd, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    exp_t e;
    bus.reg_wr_req = wr;
    bus.reg_rd_req = rd;
    bus.reg_addr   = a;
    bus.reg_wdata  = wd;
    e.data = ed;
    e.err  = ee;
    e.cyc  = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.reg_wr_req = 1'b0;
    bus.reg_rd_req = 1'b0;
  endtask

  task automatic check_cnfg(input string tag, input int unsigned m, input int unsigned p,
                            input int unsigned b, input int unsigned g);
    check({tag, "_m"}, 32'(cnfg_m), m);
    check({tag, "_p"}, 32'(cnfg_p), p);
    check({tag, "_b"}, 32'(cnfg_b), b);
    check({tag, "_g"}, 32'(cnfg_g), g);
  endtask

  // rstn was released at a negedge; iteration i ends after i rising edges
  task automatic boot_check(input bit do_read);
    for (int i = 1; i <= 10; i++) begin
      if (do_read && i == 3) bus_op(1'b0, 1'b1, AW'(A_M_SH), 32'd0, 32'd0, 1'b1);
      else @(negedge clk);
      if (i == 1 || i == 9) begin
        check("boot_en_early", 32'(ga_enable), 32'd0);
        check_cnfg("boot_early", 0, 0, 0, 0);
      end
    end
    check("boot_en", 32'(ga_enable), 32'd1);
    check_cnfg("boot_def", 7, 16, 16, 10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.reg_wr_req = 1'b0;
    bus.reg_rd_req = 1'b0;
    bus.reg_addr   = '0;
    bus.reg_wdata  = '0;
    ga_ready       = 1'b0;
    inputs_counter = CNT_VAL;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(ga_enable), 32'd0);
    check("rst_ack", 32'(bus.reg_ack), 32'd0);
    check_cnfg("rst", 0, 0, 0, 0);
    rstn = 1'b1;
    boot_check(1'b1);

    bus_op(1'b0, 1'b1, AW'(A_M_SH), 32'd0, 32'd7, 1'b0);

    // program shadows with the core busy; commit must wait
    bus_op(1'b1, 1'b0, AW'(A_M_SH), 32'd5, 32'd0, 1'b0);
    bus_op(1'b1, 1'b0, AW'(A_G_SH), 32'd1000, 32'd0, 1'b0);
    bus_op(1'b1, 1'b0, AW'(A_CTRL), 32'd3, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    check_cnfg("wait_ready", 7, 16, 16, 10);
    bus_op(1'b0, 1'b1, AW'(A_STATUS), 32'd0, 32'h2, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_G_SH), 32'd0, 32'(G_TRUNC), 1'b0);
    ga_ready = 1'b1;
    @(negedge clk);
    check_cnfg("commit", 5, 16, 16, G_TRUNC);
    bus_op(1'b0, 1'b1, AW'(A_STATUS), 32'd0, 32'h1, 1'b0);

    // error cases, each followed by status/unchanged checks and a clear
    bus_op(1'b1, 1'b0, AW'(A_P_SH), 32'd0, 32'd0, 1'b1);
    bus_op(1'b0, 1'b1, AW'(A_STATUS), 32'd0, 32'h5, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_P_SH), 32'd0, 32'd16, 1'b0);
    bus_op(1'b1, 1'b0, AW'(A_STATUS), 32'd0, 32'd0, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_STATUS), 32'd0, 32'h1, 1'b0);
    bus_op(1'b1, 1'b0, AW'(7), 32'd55, 32'd0, 1'b1);
    bus_op(1'b0, 1'b1, AW'(A_STATUS), 32'd0, 32'h5, 1'b0);
    bus_op(1'b1, 1'b0, AW'(A_STATUS), 32'd0, 32'd0, 1'b0);
    bus_op(1'b1, 1'b1, AW'(A_M_SH), 32'd9, 32'd0, 1'b1);
    bus_op(1'b0, 1'b1, AW'(A_M_SH), 32'd0, 32'd5, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_STATUS), 32'd0, 32'h5, 1'b0);
    bus_op(1'b1, 1'b0, AW'(A_STATUS), 32'd0, 32'd0, 1'b0);
    bus_op(1'b1, 1'b0, AW'(A_INPUTS), 32'd1, 32'd0, 1'b1);
    bus_op(1'b0, 1'b1, AW'(7), 32'd0, 32'd0, 1'b1);
    bus_op(1'b1, 1'b0, AW'(A_STATUS), 32'd0, 32'd0, 1'b0);
    check_cnfg("after_err", 5, 16, 16, G_TRUNC);
    check("after_err_en", 32'(ga_enable), 32'd1);

    // back-to-back reads across the whole map
    bus_op(1'b0, 1'b1, AW'(A_CTRL),   32'd0, 32'd1, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_M_SH),   32'd0, 32'd5, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_P_SH),   32'd0, 32'd16, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_B_SH),   32'd0, 32'd16, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_G_SH),   32'd0, 32'(G_TRUNC), 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_STATUS), 32'd0, 32'h1, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_INPUTS), 32'd0, CNT_VAL, 1'b0);

    // commit with core already ready: visible two edges after the request
    bus_op(1'b1, 1'b0, AW'(A_P_SH), 32'd33, 32'd0, 1'b0);
    bus_op(1'b1, 1'b0, AW'(A_CTRL), 32'd3, 32'd0, 1'b0);
    check("commit_lat1_p", 32'(cnfg_p), 32'd16);
    @(negedge clk);
    check("commit_lat2_p", 32'(cnfg_p), 32'd33);

    // shadow write landing on the commit cycle
    ga_ready = 1'b0;
    bus_op(1'b1, 1'b0, AW'(A_M_SH), 32'd12, 32'd0, 1'b0);
    bus_op(1'b1, 1'b0, AW'(A_CTRL), 32'd3, 32'd0, 1'b0);
    ga_ready = 1'b1;
    bus_op(1'b1, 1'b0, AW'(A_M_SH), 32'd9, 32'd0, 1'b0);
    check("same_cyc_act_m", 32'(cnfg_m), 32'd12);
    bus_op(1'b0, 1'b1, AW'(A_M_SH), 32'd0, 32'd9, 1'b0);
    check("same_cyc_hold_m", 32'(cnfg_m), 32'd12);

    // enable control
    bus_op(1'b1, 1'b0, AW'(A_CTRL), 32'd0, 32'd0, 1'b0);
    check("en_off", 32'(ga_enable), 32'd0);
    bus_op(1'b0, 1'b1, AW'(A_CTRL), 32'd0, 32'd0, 1'b0);
    bus_op(1'b1, 1'b0, AW'(A_CTRL), 32'd1, 32'd0, 1'b0);
    check("en_on", 32'(ga_enable), 32'd1);

    // reset while a commit is pending
    ga_ready = 1'b0;
    bus_op(1'b1, 1'b0, AW'(A_M_SH), 32'd3, 32'd0, 1'b0);
    bus_op(1'b1, 1'b0, AW'(A_CTRL), 32'd3, 32'd0, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_STATUS), 32'd0, 32'h2, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("midrst_en", 32'(ga_enable), 32'd0);
    check("midrst_ack", 32'(bus.reg_ack), 32'd0);
    check("midrst_rdata", bus.reg_rdata, 32'd0);
    check_cnfg("midrst", 0, 0, 0, 0);
    @(negedge clk);
    ga_ready = 1'b1;
    rstn = 1'b1;
    boot_check(1'b0);
    bus_op(1'b0, 1'b1, AW'(A_STATUS), 32'd0, 32'h1, 1'b0);
    bus_op(1'b0, 1'b1, AW'(A_M_SH), 32'd0, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    check_cnfg("reboot_final", 7, 16, 16, 10);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
